// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the combinational instruction memory and
// presents each fetched instruction to decode through a one-entry valid/ready register.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_RUN    | fetching; a new instruction is captured whenever the slot frees
// ST_HALTED | no fetches, pc frozen; only a redirect resumes execution
module instruction_fetch #(
    parameter int             L        = 16,
    parameter logic [L-1:0]   RESET_PC = '0,
    parameter int             PC_STEP  = 1
) (
    input  logic         clk,
    input  logic         reset,
    output logic [L-1:0] imem_addr,
    input  logic [L-1:0] imem_instr,
    input  logic         stall,
    input  logic         halt_req,
    input  logic         redirect_valid,
    input  logic [L-1:0] redirect_target,
    output logic         if_valid,
    input  logic         if_ready,
    output logic [L-1:0] if_instr,
    output logic [L-1:0] if_pc,
    output logic         halted,
    output logic [L-1:0] fetch_count
);

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_t;

    localparam logic [L-1:0] STEP    = L'(PC_STEP);
    localparam logic [L-1:0] CNT_ONE = L'(1);

    state_t       state_q, state_d;
    logic [L-1:0] pc_q, pc_d;
    logic         valid_q, valid_d;
    logic [L-1:0] instr_q, instr_d;
    logic [L-1:0] ipc_q, ipc_d;
    logic [L-1:0] count_q, count_d;

    logic accept;
    logic slot_free;
    logic fire;

    assign accept    = valid_q & if_ready;
    assign slot_free = ~valid_q | if_ready;
    assign fire      = (state_q == ST_RUN) & ~stall & ~halt_req & ~redirect_valid & slot_free;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= '0;
            ipc_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        count_d = count_q;

        // Decode can take the held instruction in any cycle, including a flushing one.
        if (accept) begin
            count_d = count_q + CNT_ONE;
        end

        if (redirect_valid) begin
            pc_d    = redirect_target;
            valid_d = 1'b0;
            state_d = ST_RUN;
        end else begin
            if ((state_q == ST_RUN) && halt_req) begin
                state_d = ST_HALTED;
            end
            if (fire) begin
                instr_d = imem_instr;
                ipc_d   = pc_q;
                valid_d = 1'b1;
                pc_d    = pc_q + STEP;
            end else if (accept) begin
                valid_d = 1'b0;
            end
        end
    end

    assign imem_addr   = pc_q;
    assign if_valid    = valid_q;
    assign if_instr    = instr_q;
    assign if_pc       = ipc_q;
    assign halted      = (state_q == ST_HALTED);
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: memory returns n at address n for 0..30 and FFFF,
// zero elsewhere; each vector drives one cycle of inputs and checks the registered outputs.
module tb_instruction_fetch;

    localparam int L = 16;

    logic         clk;
    logic         reset;
    logic [L-1:0] imem_addr;
    logic [L-1:0] imem_instr;
    logic         stall;
    logic         halt_req;
    logic         redirect_valid;
    logic [L-1:0] redirect_target;
    logic         if_valid;
    logic         if_ready;
    logic [L-1:0] if_instr;
    logic [L-1:0] if_pc;
    logic         halted;
    logic [L-1:0] fetch_count;

    int checks   = 0;
    int failures = 0;

    instruction_fetch #(.L(L), .RESET_PC('0), .PC_STEP(1)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .stall           (stall),
        .halt_req        (halt_req),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .halted          (halted),
        .fetch_count     (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        imem_instr = '0;
        if ((imem_addr <= 16'd30) || (imem_addr == 16'hFFFF)) imem_instr = imem_addr;
    end

    typedef struct {
        logic         s;
        logic         h;
        logic         rv;
        logic [L-1:0] rt;
        logic         rdy;
        logic         ev;
        logic [L-1:0] epc;
        logic [L-1:0] ein;
        logic [L-1:0] ead;
        logic         eh;
        logic [L-1:0] ecnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic s, input logic h, input logic rv,
                                input logic [L-1:0] rt, input logic rdy,
                                input logic ev, input logic [L-1:0] epc,
                                input logic [L-1:0] ein, input logic [L-1:0] ead,
                                input logic eh, input logic [L-1:0] ecnt);
        vec_t v;
        v.s = s; v.h = h; v.rv = rv; v.rt = rt; v.rdy = rdy;
        v.ev = ev; v.epc = epc; v.ein = ein; v.ead = ead; v.eh = eh; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [L-1:0] got,
                         input logic [L-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s step %0d: got %h want %h", name, idx, got, want);
        end
    endtask

    task automatic check_all(input int idx, input logic ev, input logic [L-1:0] epc,
                             input logic [L-1:0] ein, input logic [L-1:0] ead,
                             input logic eh, input logic [L-1:0] ecnt);
        check("if_valid",    idx, L'(if_valid), L'(ev));
        check("if_pc",       idx, if_pc,        epc);
        check("if_instr",    idx, if_instr,     ein);
        check("imem_addr",   idx, imem_addr,    ead);
        check("halted",      idx, L'(halted),   L'(eh));
        check("fetch_count", idx, fetch_count,  ecnt);
    endtask

    initial begin
        //                s  h  rv rt        rdy  v  if_pc     instr     addr      hlt cnt
        // streaming from reset
        vq.push_back(mk(0, 0, 0, 16'h0000, 1,   1, 16'd0,    16'd0,    16'd1,    0,  16'd0));
        vq.push_back(mk(0, 0, 0, 16'h0000, 1,   1, 16'd1,    16'd1,    16'd2,    0,  16'd1));
        vq.push_back(mk(0, 0, 0, 16'h0000, 1,   1, 16'd2,    16'd2,    16'd3,    0,  16'd2));
        vq.push_back(mk(0, 0, 0, 16'h0000, 1,   1, 16'd3,    16'd3,    16'd4,    0,  16'd3));
        vq.push_back(mk(0, 0, 0, 16'h0000, 1,   1, 16'd4,    16'd4,    16'd5,    0,  16'd4));
        vq.push_back(mk(0, 0, 0, 16'h0000, 1,   1, 16'd5,    16'd5,    16'd6,    0,  16'd5));
        // back-pressure for three cycles, then release
        vq.push_back(mk(0, 0, 0, 16'h0000, 0,   1, 16'd5,    16'd5,    16'd6,    0,  16'd5));
        vq.push_back(mk(0, 0, 0, 16'h0000, 0,   1, 16'd5,    16'd5,    16'd6,    0,  16'd5));
        vq.push_back(mk(0, 0, 0, 16'h0000, 0,   1, 16'd5,    16'd5,    16'd6,    0,  16'd5));
        vq.push_back(mk(0, 0, 0, 16'h0000, 1,   1, 16'd6,    16'd6,    16'd7,    0,  16'd6));
        // stall two cycles: held instruction drains, pc frozen at 7, resume at 7
        vq.push_back(mk(1, 0, 0, 16'h0000, 1,   0, 16'd6,    16'd6,    16'd7,    0,  16'd7));
        vq.push_back(mk(1, 0, 0, 16'h0000, 1,   0, 16'd6,    16'd6,    16'd7,    0,  16'd7));
        vq.push_back(mk(0, 0, 0, 16'h0000, 1,   1, 16'd7,    16'd7,    16'd8,    0,  16'd7));
        vq.push_back(mk(0, 0, 0, 16'h0000, 0,   1, 16'd7,    16'd7,    16'd8,    0,  16'd7));
        // redirect to 20 while held and not ready: flushed, never counted
        vq.push_back(mk(0, 0, 1, 16'd20,   0,   0, 16'd7,    16'd7,    16'd20,   0,  16'd7));
        vq.push_back(mk(0, 0, 0, 16'h0000, 0,   1, 16'd20,   16'd20,   16'd21,   0,  16'd7));
        vq.push_back(mk(0, 0, 0, 16'h0000, 1,   1, 16'd21,   16'd21,   16'd22,   0,  16'd8));
        // redirect to 25 coinciding with an accept: the accept still counts
        vq.push_back(mk(0, 0, 1, 16'd25,   1,   0, 16'd21,   16'd21,   16'd25,   0,  16'd9));
        vq.push_back(mk(0, 0, 0, 16'h0000, 0,   1, 16'd25,   16'd25,   16'd26,   0,  16'd9));
        // halt with a held instruction: stays valid, is accepted later, no new fetches
        vq.push_back(mk(0, 1, 0, 16'h0000, 0,   1, 16'd25,   16'd25,   16'd26,   1,  16'd9));
        vq.push_back(mk(0, 0, 0, 16'h0000, 0,   1, 16'd25,   16'd25,   16'd26,   1,  16'd9));
        vq.push_back(mk(0, 0, 0, 16'h0000, 1,   0, 16'd25,   16'd25,   16'd26,   1,  16'd10));
        vq.push_back(mk(0, 0, 0, 16'h0000, 1,   0, 16'd25,   16'd25,   16'd26,   1,  16'd10));
        vq.push_back(mk(0, 1, 0, 16'h0000, 1,   0, 16'd25,   16'd25,   16'd26,   1,  16'd10));
        vq.push_back(mk(1, 0, 0, 16'h0000, 1,   0, 16'd25,   16'd25,   16'd26,   1,  16'd10));
        // redirect out of halt to 30; address 31 returns 0
        vq.push_back(mk(0, 0, 1, 16'd30,   1,   0, 16'd25,   16'd25,   16'd30,   0,  16'd10));
        vq.push_back(mk(0, 0, 0, 16'h0000, 1,   1, 16'd30,   16'd30,   16'd31,   0,  16'd10));
        vq.push_back(mk(0, 0, 0, 16'h0000, 1,   1, 16'd31,   16'd0,    16'd32,   0,  16'd11));
        // redirect beats halt_req; wrap-around at FFFF
        vq.push_back(mk(0, 1, 1, 16'hFFFF, 1,   0, 16'd31,   16'd0,    16'hFFFF, 0,  16'd12));
        vq.push_back(mk(0, 0, 0, 16'h0000, 1,   1, 16'hFFFF, 16'hFFFF, 16'h0000, 0,  16'd12));
        vq.push_back(mk(0, 0, 0, 16'h0000, 1,   1, 16'h0000, 16'h0000, 16'h0001, 0,  16'd13));
        vq.push_back(mk(0, 0, 0, 16'h0000, 1,   1, 16'h0001, 16'h0001, 16'h0002, 0,  16'd14));

        reset           = 1'b1;
        stall           = 1'b0;
        halt_req        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        if_ready        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all(0, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 16'd0);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < vq.size(); i++) begin
            stall           = vq[i].s;
            halt_req        = vq[i].h;
            redirect_valid  = vq[i].rv;
            redirect_target = vq[i].rt;
            if_ready        = vq[i].rdy;
            @(posedge clk);
            #1;
            check_all(i + 1, vq[i].ev, vq[i].epc, vq[i].ein, vq[i].ead, vq[i].eh, vq[i].ecnt);
            @(negedge clk);
        end

        // mid-stream reset with a valid held instruction and a competing redirect
        stall           = 1'b0;
        halt_req        = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 16'd9;
        if_ready        = 1'b0;
        reset           = 1'b1;
        @(posedge clk);
        #1;
        check_all(100, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 16'd0);

        // halt then reset: reset leaves HALTED and the first fetch follows one cycle later
        @(negedge clk);
        reset          = 1'b0;
        redirect_valid = 1'b0;
        halt_req       = 1'b1;
        @(posedge clk);
        #1;
        check_all(101, 1'b0, 16'd0, 16'd0, 16'd0, 1'b1, 16'd0);
        @(negedge clk);
        halt_req = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        check_all(102, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 16'd0);
        @(negedge clk);
        reset    = 1'b0;
        if_ready = 1'b1;
        @(posedge clk);
        #1;
        check_all(103, 1'b1, 16'd0, 16'd0, 16'd1, 1'b0, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
